// File: rtl/parking_slot_ctrl.sv
// Entry-gate sequencer and slot allocator for an 8-slot car park.
// It grants the lowest free slot, drives the barrier, and tracks occupancy and exits.
module parking_slot_ctrl #(
  parameter int GATE_TIMEOUT = 100,
  parameter int TMR_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       entry_pass,
  input  logic       exit_req,
  input  logic [2:0] exit_slot,
  output logic [7:0] cars,
  output logic [3:0] count,
  output logic       full,
  output logic       gate_open,
  output logic [2:0] assigned_slot,
  output logic       assign_valid,
  output logic       entry_timeout,
  output logic       exit_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(GATE_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       cars_q, cars_d;
  logic [7:0]       reserved_q, reserved_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       slot_q, slot_d;
  logic             gate_q, gate_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic             err_q, err_d;

  logic [7:0] occ_c;
  logic [2:0] free_idx_c;
  logic [3:0] count_c;
  logic       full_c;

  assign occ_c  = cars_q | reserved_q;
  assign full_c = &occ_c;

  // Scanning downward leaves the lowest free index as the final assignment.
  always_comb begin
    free_idx_c = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!occ_c[i]) free_idx_c = 3'(i);
    end
  end

  always_comb begin
    count_c = '0;
    for (int i = 0; i < 8; i++) begin
      count_c = count_c + 4'(cars_q[i]);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cars_d     = cars_q;
    reserved_d = reserved_q;
    timer_d    = timer_q;
    slot_d     = slot_q;
    gate_d     = gate_q;
    valid_d    = 1'b0;
    tmo_d      = 1'b0;
    err_d      = 1'b0;

    // A reserved-but-empty slot reads as 0 in cars, so exiting it is an error.
    if (exit_req) begin
      if (cars_q[exit_slot]) cars_d[exit_slot] = 1'b0;
      else                   err_d             = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (entry_req && !full_c) begin
          reserved_d = 8'(1) << free_idx_c;
          slot_d     = free_idx_c;
          valid_d    = 1'b1;
          gate_d     = 1'b1;
          timer_d    = '0;
          state_d    = OPEN;
        end
      end
      OPEN: begin
        timer_d = timer_q + 1'b1;
        if (entry_pass) begin
          cars_d[slot_q] = 1'b1;
          reserved_d     = '0;
          gate_d         = 1'b0;
          state_d        = CLOSE;
        end else if (timer_q == TMO_LAST) begin
          reserved_d = '0;
          tmo_d      = 1'b1;
          gate_d     = 1'b0;
          state_d    = CLOSE;
        end
      end
      CLOSE: state_d = IDLE;
      default: begin
        state_d    = IDLE;
        reserved_d = '0;
        gate_d     = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cars_q     <= '0;
      reserved_q <= '0;
      timer_q    <= '0;
      slot_q     <= '0;
      gate_q     <= 1'b0;
      valid_q    <= 1'b0;
      tmo_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cars_q     <= cars_d;
      reserved_q <= reserved_d;
      timer_q    <= timer_d;
      slot_q     <= slot_d;
      gate_q     <= gate_d;
      valid_q    <= valid_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
    end
  end

  assign cars          = cars_q;
  assign count         = count_c;
  assign full          = full_c;
  assign gate_open     = gate_q;
  assign assigned_slot = slot_q;
  assign assign_valid  = valid_q;
  assign entry_timeout = tmo_q;
  assign exit_err      = err_q;

endmodule

// File: tb/tb_parking_slot_ctrl.sv
// Scoreboard bench for parking_slot_ctrl: expected grants are queued when requests
// are driven and compared whenever assign_valid pulses; scenario tasks check the rest.
module tb_parking_slot_ctrl;

  localparam int GATE_TIMEOUT = 100;
  localparam int TMR_W        = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       entry_req = 1'b0;
  logic       entry_pass = 1'b0;
  logic       exit_req = 1'b0;
  logic [2:0] exit_slot = '0;
  logic [7:0] cars;
  logic [3:0] count;
  logic       full;
  logic       gate_open;
  logic [2:0] assigned_slot;
  logic       assign_valid;
  logic       entry_timeout;
  logic       exit_err;

  int tests_run = 0;
  int tests_failed = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_slot;
  logic [7:0] cars_m;

  parking_slot_ctrl #(.GATE_TIMEOUT(GATE_TIMEOUT), .TMR_W(TMR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_req     (entry_req),
    .entry_pass    (entry_pass),
    .exit_req      (exit_req),
    .exit_slot     (exit_slot),
    .cars          (cars),
    .count         (count),
    .full          (full),
    .gate_open     (gate_open),
    .assigned_slot (assigned_slot),
    .assign_valid  (assign_valid),
    .entry_timeout (entry_timeout),
    .exit_err      (exit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // Grant monitor: pops the scoreboard on every assign_valid pulse.
  always @(posedge clk) begin
    #1;
    if (assign_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_grant: got slot %0d, expected no grant", assigned_slot);
      end else begin
        exp_slot = exp_q.pop_front();
        if (assigned_slot !== exp_slot) begin
          tests_failed++;
          $display("FAIL grant_slot: got %0d, expected %0d", assigned_slot, exp_slot);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest_free(input logic [7:0] occ);
    int r = 0;
    for (int i = 7; i >= 0; i--) if (!occ[i]) r = i;
    return r;
  endfunction

  // Full entry: request, wait pass_delay cycles with the gate open, pass, return to IDLE.
  task automatic enter_car(input int pass_delay);
    int e;
    e = lowest_free(cars_m);
    exp_q.push_back(3'(e));
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    tests_run++;
    if (gate_open !== 1'b1) begin
      tests_failed++;
      $display("FAIL enter_gate_open: got %b, expected 1", gate_open);
    end
    repeat (pass_delay) tick();
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    cars_m[e] = 1'b1;
    tests_run++;
    if (cars !== cars_m || gate_open !== 1'b0 || entry_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL enter_after_pass: cars=%h gate=%b tmo=%b, expected cars=%h gate=0 tmo=0",
               cars, gate_open, entry_timeout, cars_m);
    end
    tick();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (cars !== 8'h00 || count !== 4'd0 || full !== 1'b0 || gate_open !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: cars=%h count=%0d full=%b gate=%b, expected 00/0/0/0",
               cars, count, full, gate_open);
    end
    tests_run++;
    if (assign_valid !== 1'b0 || assigned_slot !== 3'd0 || entry_timeout !== 1'b0 || exit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses: valid=%b slot=%0d tmo=%b err=%b, expected all 0",
               assign_valid, assigned_slot, entry_timeout, exit_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cars_m = '0;
    tick();
  endtask

  task automatic test_single_entry();
    int open_cycles = 0;
    exp_q.push_back(3'd0);
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    repeat (3) begin
      if (gate_open === 1'b1) open_cycles++;
      tick();
    end
    if (gate_open === 1'b1) open_cycles++;
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    cars_m = 8'h01;
    tests_run++;
    if (open_cycles != 4) begin
      tests_failed++;
      $display("FAIL single_gate_cycles: got %0d, expected 4", open_cycles);
    end
    tests_run++;
    if (cars !== 8'h01 || count !== 4'd1 || gate_open !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_result: cars=%h count=%0d gate=%b, expected 01/1/0", cars, count, gate_open);
    end
    tick();
  endtask

  task automatic test_fill();
    for (int k = 1; k < 8; k++) enter_car(k % 3);
    tests_run++;
    if (cars !== 8'hFF || count !== 4'd8 || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL fill_status: cars=%h count=%0d full=%b, expected FF/8/1", cars, count, full);
    end
    entry_req = 1'b1;
    tick();
    tick();
    entry_req = 1'b0;
    tests_run++;
    if (gate_open !== 1'b0 || assign_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_no_grant: gate=%b valid=%b, expected 0/0", gate_open, assign_valid);
    end
    tick();
  endtask

  task automatic test_exit_and_entry();
    exit_req = 1'b1;
    exit_slot = 3'd3;
    entry_req = 1'b1;
    exp_q.push_back(3'd3);
    tick();
    exit_req = 1'b0;
    cars_m = 8'hF7;
    tests_run++;
    if (cars !== 8'hF7 || assign_valid !== 1'b0 || gate_open !== 1'b0 || exit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle_exit: cars=%h valid=%b gate=%b err=%b, expected F7/0/0/0",
               cars, assign_valid, gate_open, exit_err);
    end
    tick();
    entry_req = 1'b0;
    tests_run++;
    if (assign_valid !== 1'b1 || gate_open !== 1'b1) begin
      tests_failed++;
      $display("FAIL freed_slot_grant: valid=%b gate=%b, expected 1/1", assign_valid, gate_open);
    end
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    cars_m = 8'hFF;
    tick();
  endtask

  task automatic test_timeout();
    int open_cycles = 0;
    exit_req = 1'b1;
    exit_slot = 3'd6;
    tick();
    exit_req = 1'b0;
    cars_m = 8'hBF;
    exp_q.push_back(3'd6);
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    tests_run++;
    if (full !== 1'b1 || cars !== 8'hBF) begin
      tests_failed++;
      $display("FAIL reserved_full: full=%b cars=%h, expected 1/BF", full, cars);
    end
    for (int c = 0; c < 2 * GATE_TIMEOUT && gate_open === 1'b1; c++) begin
      open_cycles++;
      tick();
    end
    tests_run++;
    if (open_cycles != GATE_TIMEOUT) begin
      tests_failed++;
      $display("FAIL timeout_cycles: got %0d, expected %0d", open_cycles, GATE_TIMEOUT);
    end
    tests_run++;
    if (entry_timeout !== 1'b1 || cars !== 8'hBF || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulse: tmo=%b cars=%h full=%b, expected 1/BF/0", entry_timeout, cars, full);
    end
    tick();
    tests_run++;
    if (entry_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_one_cycle: got %b, expected 0", entry_timeout);
    end
    // Pass lands on the same edge the timer expires; the pass must win.
    enter_car(GATE_TIMEOUT - 1);
  endtask

  task automatic test_exit_err();
    exit_req = 1'b1;
    exit_slot = 3'd5;
    tick();
    cars_m = 8'hDF;
    tests_run++;
    if (cars !== 8'hDF || exit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL legal_exit: cars=%h err=%b, expected DF/0", cars, exit_err);
    end
    tick();
    exit_req = 1'b0;
    tests_run++;
    if (exit_err !== 1'b1 || cars !== 8'hDF) begin
      tests_failed++;
      $display("FAIL empty_exit_err: err=%b cars=%h, expected 1/DF", exit_err, cars);
    end
    tick();
    tests_run++;
    if (exit_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL exit_err_one_cycle: got %b, expected 0", exit_err);
    end
    exp_q.push_back(3'd5);
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    exit_req = 1'b1;
    exit_slot = 3'd5;
    tick();
    exit_req = 1'b0;
    tests_run++;
    if (exit_err !== 1'b1 || cars !== 8'hDF || gate_open !== 1'b1 || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL reserved_exit_err: err=%b cars=%h gate=%b full=%b, expected 1/DF/1/1",
               exit_err, cars, gate_open, full);
    end
    entry_pass = 1'b1;
    tick();
    entry_pass = 1'b0;
    cars_m = 8'hFF;
    tests_run++;
    if (cars !== 8'hFF) begin
      tests_failed++;
      $display("FAIL reserved_kept: cars=%h, expected FF", cars);
    end
    tick();
  endtask

  task automatic test_reset_mid_open();
    exit_req = 1'b1;
    exit_slot = 3'd0;
    tick();
    exit_req = 1'b0;
    cars_m = 8'hFE;
    exp_q.push_back(3'd0);
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (gate_open !== 1'b0 || cars !== 8'h00 || count !== 4'd0 || full !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: gate=%b cars=%h count=%0d full=%b, expected 0/00/0/0",
               gate_open, cars, count, full);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cars_m = '0;
    tick();
    enter_car(2);
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_fill();
    test_exit_and_entry();
    test_timeout();
    test_exit_err();
    test_reset_mid_open();
    repeat (3) tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_grants: %0d expected grants never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
